bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder_pkg.sv | 12 +
 rtl/bit_serial_adder_if.sv | 25 ++
 rtl/full_adder.sv | 18 +
 rtl/bit_serial_adder.sv | 101 ++++++++++
 tb/tb_bit_serial_adder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADD_W = 8;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Start/done handshake bundle of the bit-serial adder: operands in, result and status out.
import adder_pkg::*;

interface bit_serial_adder_if #(
    parameter int WIDTH = ADD_W
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/full_adder.sv
// One-bit gate-level full adder; the single arithmetic cell reused every cycle by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (sum, ab_x, cin);
    and g_a0 (ab_a, a, b);
    and g_a1 (cx_a, ab_x, cin);
    or  g_o0 (cout, ab_a, cx_a);
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full_adder cell processes operands LSB first, one bit per clock,
// with the carry fed back through c_q; results are registered on completion.
import adder_pkg::*;

module bit_serial_adder #(
    parameter int WIDTH = ADD_W
) (
    input logic               clk,
    input logic               rst,
    bit_serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (c_q),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    // Written as a wide shift so WIDTH=1 needs no empty slice.
    always_comb begin
        s_ext  = {fa_sum, s_sr};
        s_next = s_ext[WIDTH:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        c_q    <= bus.cin;
                        s_sr   <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    s_sr <= s_next;
                    c_q  <= fa_cout;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + CW'(1);
                    // Last bit: publish the sum including this cycle's bit.
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q  <= s_next;
                        cout_q <= fa_cout;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed table, corner sequences, random vs model.
module tb_bit_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           noise;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        string        name;
    } vec_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [W-1:0] held_sum;
    logic         held_cout;
    vec_t tbl[$];

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic.
    function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Starts at the next edge, then checks status every cycle through the done pulse.
    task automatic applyStimulus(input vec_t v, input bit scramble);
        bus.a     = v.a;
        bus.b     = v.b;
        bus.cin   = v.cin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput({v.name, " busy@1"}, {bus.busy, bus.done, bus.sum, bus.cout},
                    {1'b1, 1'b0, held_sum, held_cout});
        for (int k = 1; k <= W; k++) begin
            if (v.noise == k) begin
                bus.start = 1'b1;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
            end else if (scramble) begin
                bus.a   = W'($urandom);
                bus.b   = W'($urandom);
                bus.cin = 1'($urandom);
            end
            tick();
            bus.start = 1'b0;
            if (k < W)
                checkOutput($sformatf("%s run%0d", v.name, k), {bus.busy, bus.done, bus.sum, bus.cout},
                            {1'b1, 1'b0, held_sum, held_cout});
        end
        checkOutput({v.name, " flags"}, {bus.busy, bus.done}, 2'b01);
        checkOutput({v.name, " sum"}, bus.sum, v.exp_sum);
        checkOutput({v.name, " cout"}, bus.cout, v.exp_cout);
        held_sum  = v.exp_sum;
        held_cout = v.exp_cout;
    endtask

    task automatic idleCycle(input string name);
        tick();
        checkOutput(name, {bus.busy, bus.done, bus.sum, bus.cout}, {1'b0, 1'b0, held_sum, held_cout});
    endtask

    initial begin
        vec_t v;
        logic [W:0] r;
        vectors     = 0;
        miscompares = 0;
        held_sum    = '0;
        held_cout   = 1'b0;

        tbl.push_back('{8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, "zero"});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "ripple_ff01"});
        tbl.push_back('{8'hA5, 8'h5A, 1'b1, 0, 8'h00, 1'b1, "ripple_a55a"});
        tbl.push_back('{8'h10, 8'h20, 1'b0, 3, 8'h30, 1'b0, "ignored_start"});
        tbl.push_back('{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, "max"});
        tbl.push_back('{8'h55, 8'h22, 1'b1, 7, 8'h78, 1'b0, "late_start"});

        // Reset held with start high must not launch a run.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        tick();
        tick();
        checkOutput("reset", {bus.busy, bus.done, bus.sum, bus.cout}, 11'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        idleCycle("reset_idle");

        foreach (tbl[i]) begin
            applyStimulus(tbl[i], 1'b0);
            idleCycle({tbl[i].name, " after"});
        end

        // Back-to-back: 8'h7F+8'h01 launched in the DONE cycle of the previous add.
        applyStimulus('{8'h10, 8'h20, 1'b0, 0, 8'h30, 1'b0, "b2b_first"}, 1'b0);
        applyStimulus('{8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, "b2b_second"}, 1'b0);
        idleCycle("b2b_after");

        // Reset mid-run drops the partial result and all outputs.
        bus.a     = 8'hC3;
        bus.b     = 8'h3C;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("midrun_busy", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrun_reset", {bus.busy, bus.done, bus.sum, bus.cout}, 11'd0);
        held_sum  = '0;
        held_cout = 1'b0;
        for (int k = 0; k < W + 2; k++) idleCycle($sformatf("midrun_quiet%0d", k));
        applyStimulus('{8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, "after_reset"}, 1'b0);

        // Random operands against the arithmetic model, with random back-to-back gaps.
        for (int n = 0; n < 40; n++) begin
            v.a     = W'($urandom);
            v.b     = W'($urandom);
            v.cin   = 1'($urandom);
            v.noise = int'($urandom_range(0, W));
            r       = refAdd(v.a, v.b, v.cin);
            v.exp_sum  = r[W-1:0];
            v.exp_cout = r[W];
            v.name  = $sformatf("rand%0d", n);
            applyStimulus(v, 1'b1);
            if ($urandom_range(0, 1) == 0) idleCycle({v.name, " gap"});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
